// File: rtl/sram_pingpong_ctrl.sv
// sram_pingpong_ctrl
// Ping-pong controller in front of a single-port double-buffered SRAM.
// One buffer fills from the input stream while the other drains, one tile at
// a time, to a small output FIFO. The shared SRAM port carries at most one
// access per cycle. When both a write and a read are possible, the two
// alternate.
module sram_pingpong_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TILE_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_sel,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic [1:0]            buf_full
);

    typedef enum logic {
        GRANT_R = 1'b0,
        GRANT_W = 1'b1
    } grant_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TILE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

    // Buffer bookkeeping
    logic [1:0]            full;
    logic                  wr_buf;
    logic                  rd_buf;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    grant_t                last_grant;

    // Read pipeline: one read may be in flight while its data comes back
    logic                  rd_inflight;
    logic                  rd_tag;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_sel_q;

    // Two-entry output FIFO of {last, data}
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            fifo_count;

    logic [1:0] outstanding;
    logic       rd_elig;
    logic       wr_elig;
    logic       wr_grant;
    logic       rd_grant;
    logic       fifo_push;
    logic       fifo_pop;

    // The FIFO count plus the in-flight read never exceeds two, so the 2-bit
    // sum cannot wrap.
    assign outstanding = fifo_count + {1'b0, rd_inflight};
    assign rd_elig     = full[rd_buf] && (outstanding < 2'd2);
    assign wr_elig     = !full[wr_buf];

    // When both sides are eligible, a read goes next if the previous grant
    // was a write. This gives alternation without looking at in_valid.
    assign in_ready = !rst && wr_elig && !(rd_elig && (last_grant == GRANT_W));
    assign wr_grant = in_valid && in_ready;
    assign rd_grant = rd_elig && !wr_grant;

    assign fifo_push = rd_inflight;
    assign out_valid = (fifo_count != 2'd0);
    assign fifo_pop  = out_valid && out_ready;

    assign buf_full = full;

    // The head entry is visible only while the FIFO holds data. Stale
    // storage never reaches the output.
    assign out_data = out_valid ? fifo_data[fifo_rp] : '0;
    assign out_last = out_valid && fifo_last[fifo_rp];

    // Steer the SRAM port to the write, the read, or an idle hold of the last read address
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sram_we   = 1'b0;
        sram_sel  = rd_sel_q;
        sram_addr = rd_addr_q;
        sram_din  = '0;
        if (wr_grant) begin
            sram_we   = 1'b1;
            sram_sel  = wr_buf;
            sram_addr = wr_cnt;
            sram_din  = in_data;
        end else if (rd_grant) begin
            sram_sel  = rd_buf;
            sram_addr = rd_cnt;
        end
    end

    // Buffer fill/drain pointers, full flags, arbitration history and read tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 2'b00;
            wr_buf      <= 1'b0;
            rd_buf      <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            last_grant  <= GRANT_R;
            rd_inflight <= 1'b0;
            rd_tag      <= 1'b0;
            rd_addr_q   <= '0;
            rd_sel_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every read in this block sees pre-edge values.
            if (wr_grant) begin
                last_grant <= GRANT_W;
                if (wr_cnt == LAST_IDX) begin
                    full[wr_buf] <= 1'b1;
                    wr_buf       <= ~wr_buf;
                    wr_cnt       <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CNT_ONE;
                end
            end

            if (rd_grant) begin
                last_grant <= GRANT_R;
                rd_addr_q  <= rd_cnt;
                rd_sel_q   <= rd_buf;
                if (rd_cnt == LAST_IDX) begin
                    // The final read is already issued, so the buffer is free for refill.
                    full[rd_buf] <= 1'b0;
                    rd_buf       <= ~rd_buf;
                    rd_cnt       <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CNT_ONE;
                end
            end

            rd_inflight <= rd_grant;
            rd_tag      <= rd_grant && (rd_cnt == LAST_IDX);
        end
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wp    <= 1'b0;
            fifo_rp    <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wp <= ~fifo_wp;
            end
            if (fifo_pop) begin
                fifo_rp <= ~fifo_rp;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output FIFO storage: capture returning SRAM data with its last tag
    // NOTE: storage has no reset; the outputs are gated by out_valid, so an un-reset entry is never observed.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[fifo_wp] <= sram_dout;
            fifo_last[fifo_wp] <= rd_tag;
        end
    end

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Self-checking bench for sram_pingpong_ctrl.
// A behavioural double-buffer SRAM sits on the controller's port. The
// reference model is an ordered queue of accepted words; the tile position
// and buffer of each word follow from its index since reset.
module tb_sram_pingpong_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TL = 4;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic          sram_sel;
    logic [DW-1:0] sram_dout = '0;
    logic [1:0]    buf_full;

    sram_pingpong_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TILE_LEN  (TL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .sram_we  (sram_we),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_sel (sram_sel),
        .sram_dout(sram_dout),
        .buf_full (buf_full)
    );

    always #5 clk = ~clk;

    // Double-buffered SRAM: synchronous write, registered read
    logic [DW-1:0] mem [2][256];
    always @(posedge clk) begin
        if (sram_we) mem[sram_sel][sram_addr] <= sram_din;
        sram_dout <= mem[sram_sel][sram_addr];
    end

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_in = 0;
    int    n_out = 0;
    int    first_ov_cyc = -1;
    int    last_in_cyc = 0;
    bit    hs_in;
    bit    prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic  prev_last;
    word_t exp_q[$];

    // One clock cycle. Inputs are set by the caller at the falling edge.
    // Outputs are sampled 1 ns later, and handshakes are scored against the model.
    task automatic step();
        word_t         w;
        logic          exp_sel;
        logic [AW-1:0] exp_addr;
        #1;
        cyc++;
        hs_in = 1'b0;
        if (in_valid && in_ready) begin
            hs_in    = 1'b1;
            exp_sel  = 1'((n_in / TL) % 2);
            exp_addr = AW'(n_in % TL);
            checks++;
            if (sram_we !== 1'b1 || sram_sel !== exp_sel || sram_addr !== exp_addr || sram_din !== in_data) begin
                errors++;
                $display("FAIL write_port cyc=%0d: got we=%0b sel=%0b addr=%0d din=%h, expected we=1 sel=%0b addr=%0d din=%h",
                         cyc, sram_we, sram_sel, sram_addr, sram_din, exp_sel, exp_addr, in_data);
            end
            w.last = (n_in % TL) == TL - 1;
            w.data = in_data;
            exp_q.push_back(w);
            n_in++;
            last_in_cyc = cyc;
        end else begin
            checks++;
            if (sram_we !== 1'b0) begin
                errors++;
                $display("FAIL idle_we cyc=%0d: got sram_we=%0b, expected 0", cyc, sram_we);
            end
        end
        if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d: got valid=%0b data=%h last=%0b, expected valid=1 data=%h last=%0b",
                         cyc, out_valid, out_data, out_last, prev_data, prev_last);
            end
        end
        if (out_valid === 1'b1 && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_word cyc=%0d: got data=%h last=%0b, expected no word", cyc, out_data, out_last);
            end else begin
                w = exp_q.pop_front();
                if (out_data !== w.data || out_last !== w.last) begin
                    errors++;
                    $display("FAIL out_word cyc=%0d: got data=%h last=%0b, expected data=%h last=%0b",
                             cyc, out_data, out_last, w.data, w.last);
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        exp_q.delete();
        n_in       = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Drain everything the model still expects, within a cycle budget
    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words left, expected 0", exp_q.size());
        end
        repeat (4) step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            sram_we !== 1'b0 || buf_full !== 2'b00 || sram_addr !== '0 || sram_sel !== 1'b0 || sram_din !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ir=%0b ov=%0b ol=%0b od=%h we=%0b bf=%b addr=%h sel=%0b din=%h, expected all 0",
                     in_ready, out_valid, out_last, out_data, sram_we, buf_full, sram_addr, sram_sel, sram_din);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || buf_full !== 2'b00) begin
            errors++;
            $display("FAIL post_reset: got ir=%0b ov=%0b bf=%b, expected ir=1 ov=0 bf=00", in_ready, out_valid, buf_full);
        end
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        out_ready    = 1'b1;
        first_ov_cyc = -1;
        for (int i = 0; i < TL; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h11 + i);
            step();
            checks++;
            if (!hs_in) begin
                errors++;
                $display("FAIL t1_in_ready word %0d: got no handshake, expected in_ready=1", i);
            end
        end
        in_valid = 1'b0;
        repeat (8) step();
        checks++;
        if (first_ov_cyc != last_in_cyc + 3) begin
            errors++;
            $display("FAIL t1_latency: got first out_valid at +%0d, expected +3", first_ov_cyc - last_in_cyc);
        end
        drain(40);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int prev = 0;
        int guard = 0;
        int gap;
        do_reset();
        out_ready = 1'b1;
        while (k < 3 * TL && guard < 200) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step();
            guard++;
            if (hs_in) begin
                if (k > 0) begin
                    gap = (k < TL) ? 1 : 2;
                    checks++;
                    if (cyc - prev != gap) begin
                        errors++;
                        $display("FAIL t2_gap word %0d: got %0d cycles, expected %0d", k, cyc - prev, gap);
                    end
                end
                prev = cyc;
                k++;
            end
        end
        checks++;
        if (k != 3 * TL) begin
            errors++;
            $display("FAIL t2_accept_timeout: got %0d words, expected %0d", k, 3 * TL);
        end
        drain(100);
    endtask

    task automatic test_stall_and_release();
        int            accepted = 0;
        int            rd0_cyc = -1;
        int            hs_cyc = -1;
        logic          hs_sel = 1'b1;
        logic [AW-1:0] hs_addr = '1;
        logic [DW-1:0] pending;
        logic [DW-1:0] first_word;
        do_reset();
        pending   = DW'($urandom);
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = pending;
            step();
            if (hs_in) begin
                accepted++;
                pending = DW'($urandom);
            end
        end
        first_word = exp_q[0].data;
        #1;
        checks++;
        if (accepted != 2 * TL) begin
            errors++;
            $display("FAIL t3_accepted: got %0d, expected %0d", accepted, 2 * TL);
        end
        checks++;
        if (in_ready !== 1'b0 || buf_full !== 2'b11) begin
            errors++;
            $display("FAIL t3_full: got ir=%0b bf=%b, expected ir=0 bf=11", in_ready, buf_full);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== first_word) begin
            errors++;
            $display("FAIL t3_head: got ov=%0b data=%h, expected ov=1 data=%h", out_valid, out_data, first_word);
        end
        // Idle port holds the last read: exactly two reads of buffer 0 means address 1
        checks++;
        if (sram_we !== 1'b0 || sram_sel !== 1'b0 || sram_addr !== AW'(1)) begin
            errors++;
            $display("FAIL t3_two_reads: got we=%0b sel=%0b addr=%0d, expected we=0 sel=0 addr=1", sram_we, sram_sel, sram_addr);
        end

        // Release the output and push the third tile
        out_ready = 1'b1;
        for (int i = 0; i < 100 && accepted < 3 * TL; i++) begin
            in_valid = 1'b1;
            in_data  = pending;
            #1;
            if (rd0_cyc < 0 && !sram_we && sram_sel == 1'b0 && sram_addr == AW'(TL - 1)) rd0_cyc = cyc + 1;
            if (hs_cyc < 0 && in_ready) begin
                hs_sel  = sram_sel;
                hs_addr = sram_addr;
            end
            step();
            if (hs_in) begin
                if (hs_cyc < 0) hs_cyc = cyc;
                accepted++;
                pending = DW'($urandom);
            end
        end
        checks++;
        if (rd0_cyc < 0 || hs_cyc != rd0_cyc + 1) begin
            errors++;
            $display("FAIL t4_ready_rise: got handshake cyc=%0d, last tile0 read cyc=%0d, expected one later", hs_cyc, rd0_cyc);
        end
        checks++;
        if (hs_sel !== 1'b0 || hs_addr !== '0) begin
            errors++;
            $display("FAIL t4_third_tile: got sel=%0b addr=%0d, expected sel=0 addr=0", hs_sel, hs_addr);
        end
        checks++;
        if (accepted != 3 * TL) begin
            errors++;
            $display("FAIL t4_accepted: got %0d, expected %0d", accepted, 3 * TL);
        end
        drain(100);
    endtask

    task automatic test_reset_mid_drain();
        int k = 0;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && k < TL; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step();
            if (hs_in) k++;
        end
        in_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t5_precondition: got out_valid=%0b, expected 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sram_we !== 1'b0 || buf_full !== 2'b00 || out_data !== '0) begin
            errors++;
            $display("FAIL t5_async_reset: got ov=%0b ir=%0b we=%0b bf=%b od=%h, expected all 0",
                     out_valid, in_ready, sram_we, buf_full, out_data);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_out     = 0;
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < TL; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'hA0 + k);
            step();
            if (hs_in) k++;
        end
        drain(40);
        repeat (6) step();
        checks++;
        if (n_out != TL) begin
            errors++;
            $display("FAIL t5_word_count: got %0d words, expected %0d", n_out, TL);
        end
    endtask

    task automatic test_pulsed_ready();
        int k = 0;
        for (int i = 0; i < 400 && k < 3 * TL; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = 1'(i % 2);
            step();
            if (hs_in) k++;
        end
        checks++;
        if (k != 3 * TL) begin
            errors++;
            $display("FAIL t6_accept_timeout: got %0d words, expected %0d", k, 3 * TL);
        end
        drain(100);
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_stall_and_release();
        test_reset_mid_drain();
        test_pulsed_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
